cnn_conv_engine: RTL and testbench

Tiled fixed-point convolution layer engine: computes one CNN convolution layer from a full input feature-map array and a full weight array into a full output feature-map array. It sits between the layer memory and the next pipeline stage. A single-cycle start pulse launches it. It iterates output pixels and kernel taps, with a Tm×Tn MAC array processing output/input channel tiles. The block signals completion with a one-cycle done pulse.

---
 rtl/cnn_pkg.sv | 31 +++
 rtl/cnn_mac_array.sv | 27 ++
 rtl/cnn_conv_engine.sv | 173 +++++++++++++++++
 tb/tb_cnn_conv_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types, widths and helpers for the convolution engine.
// Q4.12 data, Q8.24 products, 40-bit Q.24 accumulators.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 12;
  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  // Drop the fraction (toward -inf) and clamp to 16-bit range
  function automatic data_t sat16(input acc_t a);
    acc_t s;
    s = a >>> FRAC_W;
    if (s > acc_t'(32767))
      return data_t'(16'h7fff);
    if (s < acc_t'(-32768))
      return data_t'(16'h8000);
    return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/cnn_mac_array.sv
// Tm x Tn signed multiplier array with one adder tree per output lane.
// Purely combinational; idle lanes are fed zero operands by the caller.
module cnn_mac_array
  import cnn_pkg::*;
#(
  parameter int Tm_p = 1,
  parameter int Tn_p = 1
) (
  input  data_t w   [Tm_p][Tn_p],
  input  data_t x   [Tn_p],
  output acc_t  sum [Tm_p]
);

  logic signed [PROD_W-1:0] prod [Tm_p][Tn_p];

  // Multiply every lane pair, then reduce across the input tile
  always_comb begin
    for (int i = 0; i < Tm_p; i++) begin
      sum[i] = '0;
      for (int j = 0; j < Tn_p; j++) begin
        prod[i][j] = PROD_W'(w[i][j]) * PROD_W'(x[j]);
        sum[i] = sum[i] + acc_t'(prod[i][j]);
      end
    end
  end

endmodule

// File: rtl/cnn_conv_engine.sv
// Tiled fixed-point convolution layer engine.
// Walks (r, c, kr, kc, n-tile, m-tile), accumulating into per-pixel sums.
module cnn_conv_engine
  import cnn_pkg::*;
#(
  parameter int N_p  = 1,
  parameter int M_p  = 1,
  parameter int K_p  = 1,
  parameter int R_p  = 4,
  parameter int C_p  = 4,
  parameter int S_p  = 1,
  parameter int Tn_p = 1,
  parameter int Tm_p = 1
) (
  input  logic  clk_i,
  input  logic  reset_i,
  input  data_t fm_i      [N_p][R_p][C_p],
  input  data_t weights_i [M_p][N_p][K_p][K_p],
  input  logic  valid_i,
  output data_t fm_o      [M_p][R_p][C_p],
  output logic  done_o
);

  localparam int ROUT = (R_p - K_p) / S_p + 1;
  localparam int COUT = (C_p - K_p) / S_p + 1;
  localparam int NT   = (N_p + Tn_p - 1) / Tn_p;
  localparam int MT   = (M_p + Tm_p - 1) / Tm_p;

  state_t state, state_nxt;
  logic   clr_en, run_en, load_en, last;
  int     r, c, kr, kc, nt, mt;

  acc_t  acc  [M_p][ROUT][COUT];
  data_t xv   [Tn_p];
  data_t wv   [Tm_p][Tn_p];
  acc_t  psum [Tm_p];

  assign last = (r == ROUT - 1) && (c == COUT - 1) &&
                (kr == K_p - 1) && (kc == K_p - 1) &&
                (nt == NT - 1) && (mt == MT - 1);

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (valid_i) state_nxt = CLEAR;
      CLEAR: state_nxt = RUN;
      RUN:   if (last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State decode into datapath enables
  always_comb begin
    clr_en  = (state == CLEAR);
    run_en  = (state == RUN);
    load_en = (state == DONE);
  end

  // Loop counters, innermost (m-tile) first
  always_ff @(posedge clk_i) begin
    if (!reset_i || clr_en) begin
      r <= 0; c <= 0; kr <= 0;
      kc <= 0; nt <= 0; mt <= 0;
    end else if (run_en) begin
      if (mt < MT - 1) mt <= mt + 1;
      else begin
        mt <= 0;
        if (nt < NT - 1) nt <= nt + 1;
        else begin
          nt <= 0;
          if (kc < K_p - 1) kc <= kc + 1;
          else begin
            kc <= 0;
            if (kr < K_p - 1) kr <= kr + 1;
            else begin
              kr <= 0;
              if (c < COUT - 1) c <= c + 1;
              else begin
                c <= 0;
                if (r < ROUT - 1) r <= r + 1;
                else r <= 0;
              end
            end
          end
        end
      end
    end
  end

  // Operand select; lanes past N_p / M_p never match and stay zero
  always_comb begin
    for (int j = 0; j < Tn_p; j++) begin
      xv[j] = '0;
      for (int nn = 0; nn < N_p; nn++)
        for (int rr = 0; rr < R_p; rr++)
          for (int cc = 0; cc < C_p; cc++)
            if (nn == nt * Tn_p + j &&
                rr == r * S_p + kr &&
                cc == c * S_p + kc)
              xv[j] = fm_i[nn][rr][cc];
    end
    for (int i = 0; i < Tm_p; i++)
      for (int j = 0; j < Tn_p; j++) begin
        wv[i][j] = '0;
        for (int mm = 0; mm < M_p; mm++)
          for (int nn = 0; nn < N_p; nn++)
            for (int a = 0; a < K_p; a++)
              for (int b = 0; b < K_p; b++)
                if (mm == mt * Tm_p + i &&
                    nn == nt * Tn_p + j &&
                    a == kr && b == kc)
                  wv[i][j] = weights_i[mm][nn][a][b];
      end
  end

  cnn_mac_array #(
    .Tm_p (Tm_p),
    .Tn_p (Tn_p)
  ) u_mac (
    .w   (wv),
    .x   (xv),
    .sum (psum)
  );

  // Accumulators: cleared before a layer, summed per RUN cycle
  always_ff @(posedge clk_i) begin
    if (!reset_i || clr_en) begin
      for (int mm = 0; mm < M_p; mm++)
        for (int ro = 0; ro < ROUT; ro++)
          for (int co = 0; co < COUT; co++)
            acc[mm][ro][co] <= '0;
    end else if (run_en) begin
      for (int mm = 0; mm < M_p; mm++)
        for (int ro = 0; ro < ROUT; ro++)
          for (int co = 0; co < COUT; co++)
            for (int i = 0; i < Tm_p; i++)
              if (ro == r && co == c && mm == mt * Tm_p + i)
                acc[mm][ro][co] <= acc[mm][ro][co] + psum[i];
    end
  end

  // Result registers: zero outside the valid region
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      done_o <= 1'b0;
      for (int mm = 0; mm < M_p; mm++)
        for (int rr = 0; rr < R_p; rr++)
          for (int cc = 0; cc < C_p; cc++)
            fm_o[mm][rr][cc] <= '0;
    end else begin
      done_o <= load_en;
      if (load_en) begin
        for (int mm = 0; mm < M_p; mm++)
          for (int rr = 0; rr < R_p; rr++)
            for (int cc = 0; cc < C_p; cc++)
              fm_o[mm][rr][cc] <= '0;
        for (int mm = 0; mm < M_p; mm++)
          for (int ro = 0; ro < ROUT; ro++)
            for (int co = 0; co < COUT; co++)
              fm_o[mm][ro][co] <= sat16(acc[mm][ro][co]);
      end
    end
  end

endmodule

// File: tb/tb_cnn_conv_engine.sv
// Scoreboard bench for cnn_conv_engine with partial channel tiles.
// Random layers are checked against a direct convolution model.
module tb_cnn_conv_engine;

  localparam int N  = 3;
  localparam int M  = 3;
  localparam int K  = 2;
  localparam int R  = 5;
  localparam int C  = 4;
  localparam int S  = 2;
  localparam int TN = 2;
  localparam int TM = 2;
  localparam int RO = 2;
  localparam int CO = 2;
  localparam int T  = RO * CO * K * K * 2 * 2;

  typedef logic [M*R*C*16-1:0] img_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i;
  logic valid_i;
  logic done_o;
  logic signed [15:0] fm [N][R][C];
  logic signed [15:0] w  [M][N][K][K];
  logic signed [15:0] fo [M][R][C];

  int chk = 0;
  int err = 0;
  int cyc = 0;

  img_t eq[$];
  int   cq[$];
  img_t prev;
  img_t last_exp;
  img_t mon_e;
  int   mon_d;

  always @(posedge clk) cyc <= cyc + 1;

  cnn_conv_engine #(
    .N_p (N), .M_p (M), .K_p (K), .R_p (R),
    .C_p (C), .S_p (S), .Tn_p (TN), .Tm_p (TM)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .fm_i      (fm),
    .weights_i (w),
    .valid_i   (valid_i),
    .fm_o      (fo),
    .done_o    (done_o)
  );

  // Direct valid convolution: sum, shift, clamp
  function automatic img_t model();
    img_t   img;
    longint s;
    img = '0;
    for (int m = 0; m < M; m++)
      for (int r = 0; r < RO; r++)
        for (int c = 0; c < CO; c++) begin
          s = 0;
          for (int n = 0; n < N; n++)
            for (int a = 0; a < K; a++)
              for (int b = 0; b < K; b++)
                s += longint'(fm[n][r*S+a][c*S+b]) *
                     longint'(w[m][n][a][b]);
          s = s >>> 12;
          if (s > 32767) s = 32767;
          if (s < -32768) s = -32768;
          img[((m*R+r)*C+c)*16 +: 16] = s[15:0];
        end
    return img;
  endfunction

  function automatic img_t cur();
    img_t img;
    for (int m = 0; m < M; m++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          img[((m*R+r)*C+c)*16 +: 16] = fo[m][r][c];
    return img;
  endfunction

  task automatic cmp_img(input string nm, input img_t e);
    img_t a;
    int   bad;
    a = cur();
    bad = -1;
    chk++;
    for (int i = M*R*C - 1; i >= 0; i--)
      if (a[i*16 +: 16] !== e[i*16 +: 16]) bad = i;
    if (bad >= 0) begin
      err++;
      $display("FAIL %s: fm_o[%0d] got %h want %h (cycle %0d)",
               nm, bad, a[bad*16 +: 16], e[bad*16 +: 16], cyc);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest pending job
  always @(negedge clk) begin
    if (reset_i === 1'b1 && done_o === 1'b1) begin
      if (eq.size() == 0) begin
        chk++;
        err++;
        $display("FAIL unexpected_done: done_o got 1 want 0 (cycle %0d)",
                 cyc);
      end else begin
        mon_e = eq.pop_front();
        mon_d = cq.pop_front();
        cmp_img("result", mon_e);
        chk++;
        if (cyc != mon_d) begin
          err++;
          $display("FAIL latency: done at cycle %0d want %0d",
                   cyc, mon_d);
        end
      end
    end
  end

  task automatic start_job(input bit expect_done, output int d);
    img_t e;
    e = model();
    @(posedge clk);
    #1;
    valid_i = 1'b1;
    d = cyc + T + 3;
    if (expect_done) begin
      last_exp = e;
      eq.push_back(e);
      cq.push_back(d);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < T + 20; i++) begin
      if (eq.size() == 0) break;
      @(posedge clk);
    end
    if (eq.size() != 0) begin
      chk++;
      err++;
      $display("FAIL timeout: %0d jobs pending want 0", eq.size());
      eq.delete();
      cq.delete();
    end
  endtask

  task automatic run_job();
    int d;
    start_job(1'b1, d);
    repeat (5) @(posedge clk);
    #1;
    cmp_img("hold", prev);
    wait_done();
    prev = last_exp;
  endtask

  task automatic fill_const(input logic [15:0] f, input logic [15:0] v);
    for (int n = 0; n < N; n++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          fm[n][r][c] = f;
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++)
        for (int a = 0; a < K; a++)
          for (int b = 0; b < K; b++)
            w[m][n][a][b] = v;
  endtask

  task automatic fill_rand(input bit full);
    for (int n = 0; n < N; n++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          fm[n][r][c] = full ? 16'($urandom) :
            16'(int'($urandom_range(0, 8191)) - 4096);
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++)
        for (int a = 0; a < K; a++)
          for (int b = 0; b < K; b++)
            w[m][n][a][b] = full ? 16'($urandom) :
              16'(int'($urandom_range(0, 8191)) - 4096);
  endtask

  initial begin
    int d;
    reset_i = 1'b0;
    valid_i = 1'b1;
    prev = '0;
    last_exp = '0;
    fill_const(16'h1000, 16'h1000);
    repeat (3) @(posedge clk);
    #1;
    chk++;
    if (done_o !== 1'b0) begin
      err++;
      $display("FAIL reset_done: got %b want 0", done_o);
    end
    cmp_img("reset", '0);
    reset_i = 1'b1;
    valid_i = 1'b0;
    repeat (4) @(posedge clk);

    // Pass-through: each output channel copies its own input channel
    fill_rand(1'b0);
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++)
        for (int a = 0; a < K; a++)
          for (int b = 0; b < K; b++)
            w[m][n][a][b] = (m == n && a == 0 && b == 0) ?
                            16'sh1000 : 16'sh0000;
    run_job();

    fill_const(16'h1000, 16'h0800);
    run_job();
    fill_const(16'h7000, 16'h7000);
    run_job();
    fill_const(16'h7000, 16'h9000);
    run_job();

    for (int i = 0; i < 8; i++) begin
      fill_rand(i[0]);
      run_job();
    end

    // Reset in the middle of RUN aborts the layer
    fill_rand(1'b0);
    start_job(1'b0, d);
    repeat (20) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    chk++;
    if (done_o !== 1'b0) begin
      err++;
      $display("FAIL abort_done: got %b want 0", done_o);
    end
    cmp_img("abort", '0);
    prev = '0;
    repeat (T + 10) @(posedge clk);
    fill_rand(1'b1);
    run_job();

    // Start pulses during RUN and during DONE are ignored
    fill_rand(1'b0);
    start_job(1'b1, d);
    repeat (10) @(posedge clk);
    #1;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    while (cyc < d - 1) begin
      @(posedge clk);
      #1;
    end
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    wait_done();
    prev = last_exp;
    repeat (T + 10) @(posedge clk);

    fill_rand(1'b1);
    run_job();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
